// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: reverse-Polish stack calculator core with a valid/ready
// command port. Holds a signed operand stack and reports top, second entry,
// depth and the status of the last completed command.
// Build option: define RPN_FAST_MUL_EN to compute MUL combinationally in the
// accept cycle; otherwise MUL runs an iterative shift-add for DATA_W cycles.
module rpn_stack_alu #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] top_data,
  output logic [DATA_W-1:0] second_data,
  output logic [DEPTH_W-1:0] depth,
  output logic              busy,
  output logic [1:0]        status
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_UFLOW = 2'd2;
  localparam logic [1:0] ST_OVF   = 2'd3;

  typedef enum logic {IDLE, MUL} state_t;

  logic [DATA_W-1:0]  stack_reg [DEPTH];
  logic [DEPTH_W-1:0] depth_reg;
  logic [1:0]         status_reg;
  state_t             state_reg;

  logic [IDX_W-1:0]  top_idx, sec_idx, push_idx;
  logic [DATA_W-1:0] a_val, b_val, sum_val, diff_val;
  logic              has1, has2, full, add_ovf, sub_ovf;

  // a wrapped 2*DATA_W product overflows when its upper bits are not a sign extension
  function automatic logic prod_ovf(input logic [2*DATA_W-1:0] p);
    return !((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]));
  endfunction

  assign top_idx  = IDX_W'(depth_reg - DEPTH_W'(1));
  assign sec_idx  = IDX_W'(depth_reg - DEPTH_W'(2));
  assign push_idx = IDX_W'(depth_reg);
  assign b_val    = stack_reg[top_idx];
  assign a_val    = stack_reg[sec_idx];
  assign has1     = (depth_reg != '0);
  assign has2     = (depth_reg >= DEPTH_W'(2));
  assign full     = (depth_reg == DEPTH_W'(DEPTH));
  assign sum_val  = a_val + b_val;
  assign diff_val = a_val - b_val;
  assign add_ovf  = (a_val[DATA_W-1] == b_val[DATA_W-1]) && (sum_val[DATA_W-1] != a_val[DATA_W-1]);
  assign sub_ovf  = (a_val[DATA_W-1] != b_val[DATA_W-1]) && (diff_val[DATA_W-1] != a_val[DATA_W-1]);

`ifdef RPN_FAST_MUL_EN
  logic [2*DATA_W-1:0] prod_fast;
  // sign-extended operands make the low 2*DATA_W bits equal the signed product
  assign prod_fast = {{DATA_W{a_val[DATA_W-1]}}, a_val} * {{DATA_W{b_val[DATA_W-1]}}, b_val};
`else
  logic [2*DATA_W-1:0] acc_reg, mcand_reg, acc_step, prod_iter;
  logic [DATA_W-1:0]   mplier_reg, mag_a, mag_b;
  logic                neg_reg;
  logic [CNT_W-1:0]    cnt_reg;

  // magnitudes are unsigned, so the most negative value maps cleanly to 2^(DATA_W-1)
  assign mag_a     = a_val[DATA_W-1] ? (~a_val + 1'b1) : a_val;
  assign mag_b     = b_val[DATA_W-1] ? (~b_val + 1'b1) : b_val;
  assign acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign prod_iter = neg_reg ? (~acc_step + 1'b1) : acc_step;
`endif

  // command execution, multiply sequencing and stack updates
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= '0;
      depth_reg  <= '0;
      status_reg <= ST_OK;
      state_reg  <= IDLE;
`ifndef RPN_FAST_MUL_EN
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PUSH: begin
                if (full) status_reg <= ST_FULL;
                else begin
                  stack_reg[push_idx] <= cmd_data;
                  depth_reg  <= depth_reg + DEPTH_W'(1);
                  status_reg <= ST_OK;
                end
              end
              OP_POP: begin
                if (!has1) status_reg <= ST_UFLOW;
                else begin
                  depth_reg  <= depth_reg - DEPTH_W'(1);
                  status_reg <= ST_OK;
                end
              end
              OP_ADD, OP_SUB: begin
                if (!has2) status_reg <= ST_UFLOW;
                else begin
                  stack_reg[sec_idx] <= (cmd_op == OP_ADD) ? sum_val : diff_val;
                  depth_reg  <= depth_reg - DEPTH_W'(1);
                  status_reg <= ((cmd_op == OP_ADD) ? add_ovf : sub_ovf) ? ST_OVF : ST_OK;
                end
              end
              OP_MUL: begin
                if (!has2) status_reg <= ST_UFLOW;
                else begin
`ifdef RPN_FAST_MUL_EN
                  stack_reg[sec_idx] <= prod_fast[DATA_W-1:0];
                  depth_reg  <= depth_reg - DEPTH_W'(1);
                  status_reg <= prod_ovf(prod_fast) ? ST_OVF : ST_OK;
`else
                  acc_reg    <= '0;
                  mcand_reg  <= {{DATA_W{1'b0}}, mag_a};
                  mplier_reg <= mag_b;
                  neg_reg    <= a_val[DATA_W-1] ^ b_val[DATA_W-1];
                  cnt_reg    <= CNT_W'(DATA_W - 1);
                  state_reg  <= MUL;
`endif
                end
              end
              OP_DUP: begin
                if (!has1) status_reg <= ST_UFLOW;
                else if (full) status_reg <= ST_FULL;
                else begin
                  stack_reg[push_idx] <= b_val;
                  depth_reg  <= depth_reg + DEPTH_W'(1);
                  status_reg <= ST_OK;
                end
              end
              OP_SWAP: begin
                if (!has2) status_reg <= ST_UFLOW;
                else begin
                  stack_reg[top_idx] <= a_val;
                  stack_reg[sec_idx] <= b_val;
                  status_reg <= ST_OK;
                end
              end
              OP_CLEAR: begin
                depth_reg  <= '0;
                status_reg <= ST_OK;
              end
              default: status_reg <= status_reg;
            endcase
          end
        end
`ifndef RPN_FAST_MUL_EN
        MUL: begin
          if (cnt_reg == '0) begin
            stack_reg[sec_idx] <= prod_iter[DATA_W-1:0];
            depth_reg  <= depth_reg - DEPTH_W'(1);
            status_reg <= prod_ovf(prod_iter) ? ST_OVF : ST_OK;
            state_reg  <= IDLE;
          end else begin
            acc_reg    <= acc_step;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CNT_W'(1);
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // display-facing outputs; empty slots read as zero regardless of stored contents
  always_comb begin
    cmd_ready   = (state_reg == IDLE);
    busy        = (state_reg != IDLE);
    top_data    = has1 ? b_val : '0;
    second_data = has2 ? a_val : '0;
    depth       = depth_reg;
    status      = status_reg;
  end

endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: directed and randomized commands for rpn_stack_alu,
// checked against a queue-based reference stack kept in the bench.
module tb_rpn_stack_alu;

  localparam int W    = 8;
  localparam int D    = 8;
  localparam int DW   = $clog2(D + 1);
  localparam int MASK = (1 << W) - 1;
`ifdef RPN_FAST_MUL_EN
  localparam int LAT = 0;
`else
  localparam int LAT = W;
`endif

  logic          CLOCK_50 = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_ready;
  logic [W-1:0]  top_data, second_data;
  logic [DW-1:0] depth;
  logic          busy;
  logic [1:0]    status;

  int n_cmp = 0;
  int n_err = 0;
  int stk[$];
  int m_status = 0;
  int op_tab[16] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 4, 4, 5, 6, 0, 1, 7};

  rpn_stack_alu #(.DATA_W(W), .DEPTH(D)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .top_data(top_data),
    .second_data(second_data), .depth(depth), .busy(busy), .status(status)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // reduce an exact integer result to its signed W-bit two's complement value
  function automatic int wrap(input int v);
    int r;
    r = v % (1 << W);
    if (r < 0) r += (1 << W);
    if (r >= (1 << (W - 1))) r -= (1 << W);
    return r;
  endfunction

  function automatic bit in_range(input int v);
    return (v >= -(1 << (W - 1))) && (v < (1 << (W - 1)));
  endfunction

  // reference stack: plain integer arithmetic on a queue
  task automatic model(input int op, input int data);
    int a, b, r;
    case (op)
      0: if (stk.size() == D) m_status = 1;
         else begin stk.push_back(wrap(data)); m_status = 0; end
      1: if (stk.size() == 0) m_status = 2;
         else begin void'(stk.pop_back()); m_status = 0; end
      2, 3, 4: if (stk.size() < 2) m_status = 2;
         else begin
           b = stk.pop_back();
           a = stk.pop_back();
           r = (op == 2) ? a + b : (op == 3) ? a - b : a * b;
           m_status = in_range(r) ? 0 : 3;
           stk.push_back(wrap(r));
         end
      5: if (stk.size() == 0) m_status = 2;
         else if (stk.size() == D) m_status = 1;
         else begin stk.push_back(stk[stk.size() - 1]); m_status = 0; end
      6: if (stk.size() < 2) m_status = 2;
         else begin
           a = stk[stk.size() - 2];
           stk[stk.size() - 2] = stk[stk.size() - 1];
           stk[stk.size() - 1] = a;
           m_status = 0;
         end
      default: begin stk.delete(); m_status = 0; end
    endcase
  endtask

  task automatic check_state();
    int n;
    n = stk.size();
    check("depth", depth, n);
    check("top", top_data, (n > 0) ? (stk[n - 1] & MASK) : 0);
    check("second", second_data, (n > 1) ? (stk[n - 2] & MASK) : 0);
    check("status", status, m_status);
    check("ready", cmd_ready, 1);
    check("busy", busy, 0);
  endtask

  // issue one command; hold keeps cmd_valid high with junk during a multiply
  task automatic do_cmd(input int op, input int data, input bit hold);
    int exp_lat, prev_st, prev_dp, cycles;
    exp_lat = (op == 4 && stk.size() >= 2) ? LAT : 0;
    prev_st = m_status;
    prev_dp = stk.size();
    cmd_valid = 1'b1;
    cmd_op    = op[2:0];
    cmd_data  = data[W-1:0];
    @(posedge CLOCK_50); #1;
    if (hold) begin
      cmd_op   = 3'($urandom_range(0, 7));
      cmd_data = W'($urandom);
    end else cmd_valid = 1'b0;
    model(op, data);
    cycles = 0;
    while (!cmd_ready && cycles < 100) begin
      check("mul_status_hold", status, prev_st);
      check("mul_depth_hold", depth, prev_dp);
      check("mul_busy", busy, 1);
      @(posedge CLOCK_50); #1;
      cycles++;
    end
    cmd_valid = 1'b0;
    check("latency", cycles, exp_lat);
    $display("cmd op=%0d data=%0d -> depth=%0d top=%0d status=%0d cycles=%0d",
             op, wrap(data), depth, $signed(top_data), status, cycles);
    check_state();
  endtask

  initial begin
    // reset state
    #2;
    check("rst_depth", depth, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_status", status, 0);
    check("rst_top", top_data, 0);
    @(negedge CLOCK_50); RESET_N = 1'b1;
    @(posedge CLOCK_50); #1;

    // push / pop / underflow
    do_cmd(0, 5, 0); do_cmd(0, 73, 0);
    check("top_73", top_data, 73);
    check("second_5", second_data, 5);
    do_cmd(1, 0, 0); do_cmd(1, 0, 0); do_cmd(1, 0, 0);
    check("pop_uflow", status, 2);

    // negative multiply then add
    do_cmd(0, -1, 0); do_cmd(0, -5, 0); do_cmd(4, 0, 0);
    check("mul_5", top_data, 5);
    do_cmd(0, 8, 0); do_cmd(2, 0, 0);
    check("add_13", top_data, 13);
    do_cmd(7, 0, 0);

    // full stack
    for (int i = 1; i <= 9; i++) do_cmd(0, i * 11, 0);
    check("full_status", status, 1);
    check("full_top", top_data, 88);
    do_cmd(5, 0, 0);
    check("dup_full", status, 1);
    do_cmd(7, 0, 0);

    // arithmetic overflow and plain subtract
    do_cmd(0, 100, 0); do_cmd(0, 100, 0); do_cmd(2, 0, 0);
    check("add_ovf_val", top_data, 8'hC8);
    check("add_ovf_st", status, 3);
    do_cmd(0, 16, 0); do_cmd(0, 16, 0); do_cmd(4, 0, 0);
    check("mul_ovf_val", top_data, 0);
    check("mul_ovf_st", status, 3);
    do_cmd(0, 3, 0); do_cmd(0, 10, 0); do_cmd(3, 0, 0);
    check("sub_val", top_data, 8'hF9);
    do_cmd(0, -128, 0); do_cmd(0, -1, 0); do_cmd(4, 0, 0);
    do_cmd(7, 0, 0);

    // reset in the middle of a multiply
    do_cmd(0, 6, 0); do_cmd(0, 7, 0);
    cmd_valid = 1'b1; cmd_op = 3'd4;
    @(posedge CLOCK_50); #1;
    cmd_valid = 1'b0;
    check("mul_ready_low", cmd_ready, (LAT > 0) ? 0 : 1);
    repeat (3) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b0;
    #1;
    stk.delete(); m_status = 0;
    check("arst_depth", depth, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_status", status, 0);
    @(negedge CLOCK_50); RESET_N = 1'b1;
    @(posedge CLOCK_50); #1;
    do_cmd(0, 2, 0);

    // swap, binary underflow, valid held through multiply
    do_cmd(0, 1, 0); do_cmd(0, 2, 0); do_cmd(6, 0, 0);
    check("swap_top", top_data, 1);
    do_cmd(7, 0, 0); do_cmd(0, 9, 0); do_cmd(2, 0, 0);
    check("add_uflow", status, 2);
    do_cmd(0, 3, 0); do_cmd(4, 0, 1);
    check("mul_held_depth", depth, 1);

    // randomized command stream
    for (int i = 0; i < 400; i++) begin
      int r, d;
      r = $urandom_range(0, 15);
      d = (($urandom & 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      do_cmd(op_tab[r], d, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
